// File: rtl/redmule_exp_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : redmule_exp_stream_scheduler
// Purpose  : Schedules the MX shared-exponent streams. Each channel's element
//            count is turned into a number of memory beats. Those beats are
//            issued to the channel's streamer as bursts of at most MAX_BURST
//            beats, using a req/done handshake. All channels run
//            independently. A single done_o pulse marks the point where every
//            channel has drained.
// Ports    : clk_i, rst_ni (async, active-low), clear_i (sync clear)
//            start_i, mx_enable_i, base_addr_i, num_elems_i  - job setup
//            ready_start_i, done_i                           - streamer status
//            req_start_o, addr_o, len_o                      - streamer request
//            busy_o, done_o                                  - job status
// Revision : 1.0 - initial release
// ============================================================================
module redmule_exp_stream_scheduler #(
  parameter int unsigned NCH       = 2,
  parameter int unsigned AW        = 32,
  parameter int unsigned BLK       = 32,
  parameter int unsigned EXP_B     = 1,
  parameter int unsigned BEAT_B    = 64,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned LW        = $clog2(MAX_BURST) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic              mx_enable_i,
  input  logic [NCH*AW-1:0] base_addr_i,
  input  logic [NCH*32-1:0] num_elems_i,
  input  logic [NCH-1:0]    ready_start_i,
  input  logic [NCH-1:0]    done_i,
  output logic [NCH-1:0]    req_start_o,
  output logic [NCH*AW-1:0] addr_o,
  output logic [NCH*LW-1:0] len_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned LOG_BLK  = $clog2(BLK);
  localparam int unsigned LOG_EXP  = $clog2(EXP_B);
  localparam int unsigned LOG_BEAT = $clog2(BEAT_B);
  // 33 bits hold ceil() of a full 32-bit count; the extra bits cover the
  // byte scaling when one exponent is wider than a byte.
  localparam int unsigned CW       = 33 + LOG_EXP;

  typedef enum logic [1:0] {IDLE, CALC, RUN, FIN} state_t;
  typedef enum logic [1:0] {CH_IDLE, CH_REQ, CH_WAIT, CH_DONE} ch_state_t;

  state_t            r_state;
  logic              r_mx;
  ch_state_t         r_ch  [NCH];
  logic [CW-1:0]     r_rem [NCH];  // holds the element count until CALC
  logic [AW-1:0]     r_cur [NCH];
  logic [LW-1:0]     w_len [NCH];
  logic [NCH-1:0]    w_active;
  logic              w_all_done;

  // Element count -> beats, rounding up at both the block and the beat step.
  function automatic logic [CW-1:0] calc_beats(input logic [31:0] n);
    logic [CW-1:0] blocks;
    logic [CW-1:0] bytes;
    blocks = (CW'(n) + CW'(BLK - 1)) >> LOG_BLK;
    bytes  = blocks << LOG_EXP;
    return (bytes + CW'(BEAT_B - 1)) >> LOG_BEAT;
  endfunction

  always_comb begin
    w_all_done = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      if (r_ch[c] != CH_DONE) w_all_done = 1'b0;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign w_len[c]    = (r_rem[c] > CW'(MAX_BURST)) ? LW'(MAX_BURST)
                                                     : r_rem[c][LW-1:0];
    assign w_active[c] = (r_ch[c] == CH_REQ) || (r_ch[c] == CH_WAIT);
    assign req_start_o[c]         = (r_ch[c] == CH_REQ) & ready_start_i[c];
    assign addr_o[c*AW +: AW]     = w_active[c] ? r_cur[c] : '0;
    assign len_o[c*LW +: LW]      = w_active[c] ? w_len[c] : '0;
  end

  assign busy_o = (r_state != IDLE);
  assign done_o = (r_state == FIN);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_mx    <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        r_ch[c]  <= CH_IDLE;
        r_rem[c] <= '0;
        r_cur[c] <= '0;
      end
    end else if (clear_i) begin
      r_state <= IDLE;
      r_mx    <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        r_ch[c]  <= CH_IDLE;
        r_rem[c] <= '0;
        r_cur[c] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_mx <= mx_enable_i;
            for (int c = 0; c < NCH; c++) begin
              r_cur[c] <= base_addr_i[c*AW +: AW];
              r_rem[c] <= CW'(num_elems_i[c*32 +: 32]);
            end
            r_state <= CALC;
          end
        end
        CALC: begin
          for (int c = 0; c < NCH; c++) begin
            r_rem[c] <= calc_beats(r_rem[c][31:0]);
            if (!r_mx || (calc_beats(r_rem[c][31:0]) == '0)) r_ch[c] <= CH_DONE;
            else                                           r_ch[c] <= CH_REQ;
          end
          r_state <= RUN;
        end
        RUN: begin
          for (int c = 0; c < NCH; c++) begin
            case (r_ch[c])
              CH_REQ: begin
                if (ready_start_i[c]) r_ch[c] <= CH_WAIT;
              end
              CH_WAIT: begin
                if (done_i[c]) begin
                  r_cur[c] <= r_cur[c] + (AW'(w_len[c]) << LOG_BEAT);
                  r_rem[c] <= r_rem[c] - CW'(w_len[c]);
                  r_ch[c]  <= (r_rem[c] == CW'(w_len[c])) ? CH_DONE : CH_REQ;
                end
              end
              default: ;
            endcase
          end
          if (w_all_done) r_state <= FIN;
        end
        FIN: begin
          for (int c = 0; c < NCH; c++) r_ch[c] <= CH_IDLE;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_redmule_exp_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_redmule_exp_stream_scheduler
// Purpose  : Self-checking bench for redmule_exp_stream_scheduler. Each job's
//            request list is computed from the element counts, and streamer
//            ready/done behaviour is randomised against that list.
// Revision : 1.0 - initial release
// ============================================================================
module tb_redmule_exp_stream_scheduler;

  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int LW  = 5;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              clear_i;
  logic              start_i;
  logic              mx_enable_i;
  logic [NCH*AW-1:0] base_addr_i;
  logic [NCH*32-1:0] num_elems_i;
  logic [NCH-1:0]    ready_start_i;
  logic [NCH-1:0]    done_i;
  logic [NCH-1:0]    req_start_o;
  logic [NCH*AW-1:0] addr_o;
  logic [NCH*LW-1:0] len_o;
  logic              busy_o;
  logic              done_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed { logic [31:0] a; logic [4:0] l; } req_t;

  always #5 clk_i = ~clk_i;

  redmule_exp_stream_scheduler #(
    .NCH(NCH), .AW(AW), .BLK(32), .EXP_B(1), .BEAT_B(64), .MAX_BURST(16), .LW(LW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .mx_enable_i(mx_enable_i), .base_addr_i(base_addr_i), .num_elems_i(num_elems_i),
    .ready_start_i(ready_start_i), .done_i(done_i), .req_start_o(req_start_o),
    .addr_o(addr_o), .len_o(len_o), .busy_o(busy_o), .done_o(done_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Beats per channel straight from the rounding rules, in 64-bit arithmetic.
  function automatic longint exp_beats(input longint n);
    longint blocks, bytes;
    blocks = (n + 31) / 32;
    bytes  = blocks * 1;
    return (bytes + 63) / 64;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},  64'(req_start_o), 64'd0);
    chk({tag, "_addr"}, addr_o, 64'd0);
    chk({tag, "_len"},  64'(len_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
  endtask

  task automatic randomize_setup();
    base_addr_i = {$urandom, $urandom};
    num_elems_i = {$urandom, $urandom};
    mx_enable_i = 1'($urandom_range(0, 1));
  endtask

  // abort_at = 0: run to completion. Otherwise abort at that cycle with
  // clear_i (abort_kind 0) or an asynchronous rst_ni pulse (abort_kind 1).
  task automatic run_job(input logic [31:0] b0, input logic [31:0] b1,
                         input logic [31:0] n0, input logic [31:0] n1,
                         input logic mx, input int ready_pct,
                         input int abort_at, input int abort_kind);
    req_t        q [2][$];
    logic [31:0] last_a [2];
    logic [4:0]  last_l [2];
    bit          outst [2];
    int          cnt [2];
    logic [31:0] nn [2];
    logic [31:0] bb [2];
    logic [1:0]  rdy, dn;
    int          fin;
    bit          finished;
    nn[0] = n0; nn[1] = n1; bb[0] = b0; bb[1] = b1;
    for (int c = 0; c < 2; c++) begin
      longint      beats, l;
      logic [31:0] a;
      outst[c] = 0; cnt[c] = 0; last_a[c] = '0; last_l[c] = '0;
      beats = mx ? exp_beats(longint'(nn[c])) : 0;
      a = bb[c];
      while (beats > 0) begin
        l = (beats > 16) ? 16 : beats;
        q[c].push_back('{a: a, l: 5'(l)});
        a = a + 32'(l * 64);
        beats -= l;
      end
    end

    // start cycle (t)
    @(negedge clk_i);
    start_i = 1'b1; mx_enable_i = mx;
    base_addr_i = {b1, b0}; num_elems_i = {n1, n0};
    ready_start_i = 2'($urandom); done_i = '0;
    #1;
    chk("start_busy", 64'(busy_o), 64'd0);
    // CALC cycle (t+1); setup inputs scrambled to show they were latched
    @(negedge clk_i);
    start_i = 1'b0; randomize_setup();
    ready_start_i = 2'b11;
    #1;
    chk("calc_busy", 64'(busy_o), 64'd1);
    chk("calc_req",  64'(req_start_o), 64'd0);
    chk("calc_done", 64'(done_o), 64'd0);

    fin = (q[0].size() == 0 && q[1].size() == 0) ? 3 : -1;
    finished = 0;
    for (int cyc = 2; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      if (abort_at != 0 && cyc == abort_at) begin
        if (abort_kind == 0) begin
          clear_i = 1'b1; done_i = '0;
          @(negedge clk_i);
          clear_i = 1'b0; ready_start_i = 2'b11; done_i = 2'b11;
          #1;
          chk_all_zero("clear");
        end else begin
          ready_start_i = 2'b11; done_i = '0;
          #2 rst_ni = 1'b0;
          #1;
          chk_all_zero("arst");
          @(negedge clk_i);
          rst_ni = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
          @(negedge clk_i);
          ready_start_i = 2'b11; done_i = (k % 2 == 0) ? 2'b00 : 2'b11;
          #1;
          chk_all_zero("post_abort");
        end
        done_i = '0; ready_start_i = '0;
        return;
      end
      start_i = ((fin < 0 || cyc <= fin) && $urandom_range(0, 9) == 0);
      if (start_i) randomize_setup();
      for (int c = 0; c < 2; c++) begin
        rdy[c] = ($urandom_range(0, 99) < ready_pct);
        dn[c]  = 1'b0;
        if (outst[c]) begin
          if (cnt[c] == 0) dn[c] = 1'b1;
          else cnt[c]--;
        end else begin
          dn[c] = ($urandom_range(0, 5) == 0);  // must be ignored
        end
      end
      ready_start_i = rdy; done_i = dn;
      #1;
      chk("done_o", 64'(done_o), 64'(cyc == fin));
      chk("busy_o", 64'(busy_o), 64'(fin < 0 || cyc <= fin));
      for (int c = 0; c < 2; c++) begin
        bit          exp_req;
        logic [31:0] ea;
        logic [4:0]  el;
        exp_req = !outst[c] && (q[c].size() > 0) && rdy[c];
        if (outst[c])            begin ea = last_a[c];  el = last_l[c];  end
        else if (q[c].size() > 0) begin ea = q[c][0].a; el = q[c][0].l; end
        else                     begin ea = '0;         el = '0;         end
        chk("req_start", 64'(req_start_o[c]), 64'(exp_req));
        chk("addr",      64'(addr_o[c*AW +: AW]), 64'(ea));
        chk("len",       64'(len_o[c*LW +: LW]), 64'(el));
        if (outst[c] && dn[c]) outst[c] = 0;
        if (exp_req) begin
          last_a[c] = q[c][0].a; last_l[c] = q[c][0].l;
          void'(q[c].pop_front());
          outst[c] = 1; cnt[c] = $urandom_range(0, 4);
        end
      end
      if (fin < 0 && q[0].size() == 0 && q[1].size() == 0 && !outst[0] && !outst[1])
        fin = cyc + 2;
      if (fin >= 0 && cyc == fin + 1) begin
        finished = 1;
        break;
      end
    end
    chk("job_timeout", 64'(finished), 64'd1);
    start_i = 1'b0; done_i = '0; ready_start_i = '0;
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; mx_enable_i = 1'b0;
    base_addr_i = '0; num_elems_i = '0; ready_start_i = '0; done_i = '0;
    repeat (3) @(negedge clk_i);
    ready_start_i = 2'b11;
    #1;
    chk_all_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk_all_zero("after_reset");

    // one 2-beat request on ch0, ch1 idle
    run_job(32'h1000, 32'h5000, 32'd4096, 32'd0, 1'b1, 100, 0, 0);
    // 49 beats -> 16/16/16/1
    run_job(32'h2000, 32'h3000, 32'd100000, 32'd2049, 1'b1, 100, 0, 0);
    // rounding edges
    run_job(32'h4000, 32'h6000, 32'd1, 32'd2048, 1'b1, 70, 0, 0);
    run_job(32'hFFFF_FF80, 32'h0, 32'd2049, 32'd33, 1'b1, 50, 0, 0);
    // heavy backpressure
    run_job(32'h8000, 32'h9000, 32'd60000, 32'd40000, 1'b1, 10, 0, 0);
    // MX disabled -> no requests
    run_job(32'h1000, 32'h2000, 32'd50000, 32'd50000, 1'b0, 100, 0, 0);
    // full 32-bit count (first bursts must be 16 beats), cleared mid-run
    run_job(32'hA000, 32'hB000, 32'hFFFF_FFFF, 32'd4096, 1'b1, 100, 12, 0);
    run_job(32'h1000, 32'h7000, 32'd5000, 32'd9000, 1'b1, 60, 0, 0);
    // asynchronous reset mid-run, then a fresh job
    run_job(32'hC000, 32'hD000, 32'd90000, 32'hFFFF_FFFF, 1'b1, 100, 9, 1);
    run_job(32'h3000, 32'h4000, 32'd33000, 32'd2047, 1'b1, 80, 0, 0);

    for (int j = 0; j < 6; j++) begin
      logic [31:0] rn0, rn1;
      rn0 = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 120000));
      rn1 = 32'($urandom_range(0, 120000));
      run_job($urandom, $urandom, rn0, rn1, 1'b1, $urandom_range(20, 100), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
